// File: rtl/laika_skaititajs.sv
// Countdown timer for the binary-number guessing game.
// Takes start/stop requests from the game FSM, counts the round time down
// one second at a time and raises end_f when the time runs out. The remaining
// seconds are exported as binary and as two BCD digits for the display.
module laika_skaititajs #(
    parameter int CLK_HZ   = 50000000,
    parameter int MAX_TIME = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       time_f,
    input  logic [4:0] time_v,
    input  logic       stop,
    output logic       end_f,
    output logic       running,
    output logic       tick,
    output logic [4:0] time_left,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
    localparam logic [4:0]    MAX_T    = 5'(MAX_TIME);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED,
        EXPIRED
    } state_t;

    // Bit 0 carries time_f, bit 1 carries stop.
    logic [1:0] async_in;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] edge_reg;
    logic [1:0] armed_reg;
    logic [1:0] pulse;
    logic [1:0] fill_reg;

    logic       start_p;
    logic       stop_p;

    state_t          state_reg, state_next;
    logic [4:0]      time_left_reg, time_left_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [4:0]      load_val;

    assign async_in = {stop, time_f};

    // fill_reg[1] goes high once sync2_reg holds a real sample after reset,
    // so the armed flags only trust the chain after it has filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg <= 2'b00;
        end else begin
            fill_reg <= {fill_reg[0], 1'b1};
        end
    end

    // Per-input synchroniser, edge register and arm flag. An input must be
    // seen low after reset before its rising edge is accepted, so a level held
    // high across reset never starts or stops the timer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                    edge_reg[gi]  <= 1'b0;
                    armed_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= async_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                    edge_reg[gi]  <= sync2_reg[gi];
                    armed_reg[gi] <= armed_reg[gi] | (fill_reg[1] & ~sync2_reg[gi]);
                end
            end
            assign pulse[gi] = sync2_reg[gi] & ~edge_reg[gi] & armed_reg[gi];
        end
    endgenerate

    assign start_p = pulse[0];
    assign stop_p  = pulse[1];

    // State, remaining time and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            time_left_reg <= 5'd0;
            presc_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            time_left_reg <= time_left_next;
            presc_reg     <= presc_next;
        end
    end

    // Next-state logic: a start always wins, then stop, then the second tick.
    always_comb begin
        state_next     = state_reg;
        time_left_next = time_left_reg;
        presc_next     = presc_reg;
        tick           = 1'b0;
        load_val       = (time_v > MAX_T) ? MAX_T : time_v;

        if (start_p) begin
            time_left_next = load_val;
            presc_next     = '0;
            state_next     = (load_val == 5'd0) ? EXPIRED : RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    if (stop_p) begin
                        state_next = HALTED;
                    end else if (presc_reg == PRESC_TC) begin
                        presc_next = '0;
                        if (time_left_reg != 5'd0) begin
                            tick           = 1'b1;
                            time_left_next = time_left_reg - 5'd1;
                        end
                        if (time_left_reg <= 5'd1) begin
                            state_next = EXPIRED;
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // BCD split of the remaining time (values never exceed 31).
    always_comb begin
        tens = 4'd0;
        ones = 4'd0;
        if (time_left_reg >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(time_left_reg - 5'd30);
        end else if (time_left_reg >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(time_left_reg - 5'd20);
        end else if (time_left_reg >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(time_left_reg - 5'd10);
        end else begin
            ones = 4'(time_left_reg);
        end
    end

    assign running   = (state_reg == RUN);
    assign end_f     = (state_reg == EXPIRED);
    assign time_left = time_left_reg;

endmodule

// File: tb/tb_laika_skaititajs.sv
// Self-checking bench for the countdown timer. Every start pushes the
// time_left values expected at each tick onto a scoreboard queue; a monitor
// pops and compares them whenever the DUT pulses tick.
module tb_laika_skaititajs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       time_f;
    logic [4:0] time_v;
    logic       stop;
    logic       end_f;
    logic       running;
    logic       tick;
    logic [4:0] time_left;
    logic [3:0] tens;
    logic [3:0] ones;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int sb_q[$];
    int exp_tl;

    laika_skaititajs #(
        .CLK_HZ   (10),
        .MAX_TIME (30)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .time_f    (time_f),
        .time_v    (time_v),
        .stop      (stop),
        .end_f     (end_f),
        .running   (running),
        .tick      (tick),
        .time_left (time_left),
        .tens      (tens),
        .ones      (ones)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input integer got, input integer exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Scoreboard monitor: each tick must match the next expected value.
    always @(negedge clk) begin
        if (rst_n && tick) begin
            check("tick_expected", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
                exp_tl = sb_q.pop_front();
                check("tick_time_left", time_left, exp_tl);
            end
        end
    end

    task automatic push_run(input int v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v - i);
    endtask

    task automatic start_count(input int v, output int lc);
        int  ld;
        bit  ok;
        ld = (v > 30) ? 30 : v;
        ok = 1'b0;
        @(posedge clk);
        #2;
        time_v = 5'(v);
        time_f = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (running == (ld != 0) && end_f == (ld == 0)) begin
                ok = 1'b1;
                break;
            end
        end
        lc = cyc;
        time_f = 1'b0;
        check("start_latency", ok, 1);
    endtask

    task automatic wait_tick(output int t);
        bit ok;
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (tick) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        check("tick_seen", ok, 1);
    endtask

    task automatic wait_end(input int max_cyc, output int t);
        bit ok;
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (end_f) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        check("end_seen", ok, 1);
    endtask

    task automatic stop_pulse();
        @(posedge clk);
        #2 stop = 1'b1;
        repeat (4) @(posedge clk);
        #2 stop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lc;
        int t;
        int t2;

        rst_n  = 1'b0;
        time_f = 1'b0;
        stop   = 1'b0;
        time_v = 5'd0;
        #23;
        check("rst_time_left", time_left, 0);
        check("rst_tens", tens, 0);
        check("rst_ones", ones, 0);
        check("rst_running", running, 0);
        check("rst_end_f", end_f, 0);
        check("rst_tick", tick, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Normal countdown from 5.
        push_run(5, 5);
        start_count(5, lc);
        check("norm_load", time_left, 5);
        wait_tick(t);
        check("norm_first_tick", t - lc, 9);
        for (int k = 1; k < 5; k++) begin
            wait_tick(t2);
            check("norm_tick_gap", t2 - t, 10);
            t = t2;
        end
        wait_end(20, t2);
        check("norm_end_at", t2 - lc, 50);
        check("norm_end_tl", time_left, 0);
        repeat (20) @(negedge clk);
        check("norm_end_hold", end_f, 1);

        // Clamp and BCD.
        push_run(30, 1);
        start_count(31, lc);
        check("clamp_tl", time_left, 30);
        check("clamp_tens", tens, 3);
        check("clamp_ones", ones, 0);
        wait_tick(t);
        @(negedge clk);
        check("bcd_tl", time_left, 29);
        check("bcd_tens", tens, 2);
        check("bcd_ones", ones, 9);
        stop_pulse();
        check("clamp_halt_run", running, 0);
        check("clamp_halt_tl", time_left, 29);

        // Zero load goes straight to expired with no tick.
        start_count(0, lc);
        check("zero_end_f", end_f, 1);
        check("zero_tl", time_left, 0);
        check("zero_running", running, 0);
        repeat (30) @(negedge clk);
        check("zero_end_hold", end_f, 1);

        // Stop after three ticks, hold, then restart with 3.
        push_run(10, 3);
        start_count(10, lc);
        for (int k = 0; k < 3; k++) wait_tick(t);
        stop_pulse();
        repeat (50) @(negedge clk);
        check("stop_tl", time_left, 7);
        check("stop_end_f", end_f, 0);
        check("stop_running", running, 0);
        push_run(3, 3);
        start_count(3, lc);
        wait_end(40, t2);
        check("restart_end_at", t2 - lc, 30);
        check("restart_tl", time_left, 0);

        // Stop lands in the final terminal-count cycle with time_left=1.
        start_count(1, lc);
        repeat (7) @(posedge clk);
        #2 stop = 1'b1;
        repeat (4) @(posedge clk);
        #2 stop = 1'b0;
        repeat (3) @(negedge clk);
        check("race_running", running, 0);
        check("race_tl", time_left, 1);
        check("race_end_f", end_f, 0);
        repeat (20) @(negedge clk);
        check("race_hold_tl", time_left, 1);

        // Start and stop coincident while running: reload wins.
        start_count(9, lc);
        @(posedge clk);
        #2;
        time_v = 5'd4;
        time_f = 1'b1;
        stop   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("coinc_running", running, 1);
        check("coinc_tl", time_left, 4);
        check("coinc_ones", ones, 4);
        stop = 1'b0;

        // Asynchronous reset mid-count with time_f still held high.
        #2 rst_n = 1'b0;
        #1;
        check("arst_tl", time_left, 0);
        check("arst_ones", ones, 0);
        check("arst_running", running, 0);
        check("arst_end_f", end_f, 0);
        check("arst_tick", tick, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("held_no_start", running, 0);
        check("held_tl", time_left, 0);
        time_f = 1'b0;
        repeat (4) @(posedge clk);
        push_run(2, 2);
        start_count(2, lc);
        wait_end(30, t2);
        check("post_rst_end_at", t2 - lc, 20);

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
